// File: rtl/sonar_ping_ctrl.sv
// Sonar ping sequencer: clear -> TX burst -> receiver blanking -> listen for echo.
// All phase timing counts ce_pcm ticks; time-of-flight is measured from BURST entry.
module sonar_ping_ctrl #(
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce_pcm,
  input  logic          start,
  input  logic          repeat_en,
  input  logic          abort,
  input  logic [CW-1:0] burst_len,
  input  logic [CW-1:0] blank_len,
  input  logic [CW-1:0] listen_len,
  input  logic          cmp,
  output logic          mclear,
  output logic          tx_out,
  output logic          busy,
  output logic          tof_valid,
  output logic          timeout,
  output logic [CW-1:0] tof,
  output logic [2:0]    state_o
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StClear  = 3'd1,
    StBurst  = 3'd2,
    StBlank  = 3'd3,
    StListen = 3'd4,
    StDone   = 3'd5
  } state_e;

  localparam logic [CW-1:0] AllOnes = '1;
  localparam logic [CW-1:0] One     = 1;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;    // ticks seen in the current phase
  logic [CW-1:0] len_q, len_d;    // length of the current phase, latched on entry
  logic [CW-1:0] tofc_q, tofc_d;  // ticks since BURST entry
  logic [CW-1:0] tof_q, tof_d;
  logic          tx_q, tx_d;
  logic          cmp_q;
  logic          valid_q, valid_d;
  logic          tmo_q, tmo_d;
  logic          phase_done;
  logic          echo;
  logic          timing;

  assign phase_done = (cnt_q >= len_q);
  assign echo       = cmp & ~cmp_q;
  assign timing     = (state_q == StBurst) || (state_q == StBlank) || (state_q == StListen);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      len_q   <= '0;
      tofc_q  <= '0;
      tof_q   <= '0;
      tx_q    <= 1'b0;
      cmp_q   <= 1'b0;
      valid_q <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      tofc_q  <= tofc_d;
      tof_q   <= tof_d;
      tx_q    <= tx_d;
      cmp_q   <= cmp;
      valid_q <= valid_d;
      tmo_q   <= tmo_d;
    end
  end

  // Next-state logic: abort overrides everything, otherwise walk the ping phases
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    tofc_d  = tofc_q;
    tof_d   = tof_q;
    tx_d    = tx_q;
    valid_d = 1'b0;
    tmo_d   = 1'b0;

    // Saturating flight-time counter; the capture below uses the pre-increment value
    if (ce_pcm && timing && (tofc_q != AllOnes)) begin
      tofc_d = tofc_q + One;
    end

    if (abort) begin
      state_d = StIdle;
      cnt_d   = '0;
      tx_d    = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start || repeat_en) state_d = StClear;
        end
        StClear: begin
          state_d = StBurst;
          cnt_d   = '0;
          tofc_d  = '0;
          len_d   = burst_len;
          tx_d    = 1'b0;
        end
        StBurst: begin
          if (phase_done) begin
            state_d = StBlank;
            cnt_d   = '0;
            len_d   = blank_len;
            tx_d    = 1'b0;
          end else if (ce_pcm) begin
            tx_d  = ~tx_q;
            cnt_d = cnt_q + One;
          end
        end
        StBlank: begin
          if (phase_done) begin
            state_d = StListen;
            cnt_d   = '0;
            len_d   = listen_len;
          end else if (ce_pcm) begin
            cnt_d = cnt_q + One;
          end
        end
        StListen: begin
          // Echo takes precedence over a simultaneous window expiry
          if (echo) begin
            state_d = StDone;
            cnt_d   = '0;
            tof_d   = tofc_q;
            valid_d = 1'b1;
          end else if (phase_done) begin
            state_d = StDone;
            cnt_d   = '0;
            tof_d   = AllOnes;
            tmo_d   = 1'b1;
          end else if (ce_pcm) begin
            cnt_d = cnt_q + One;
          end
        end
        StDone: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // tx is blanked on the burst exit clock and whenever abort is asserted
  assign tx_out    = (state_q == StBurst) && tx_q && !phase_done && !abort;
  assign mclear    = (state_q == StClear) && !abort;
  assign busy      = (state_q != StIdle);
  assign tof_valid = valid_q;
  assign timeout   = tmo_q;
  assign tof       = tof_q;
  assign state_o   = state_q;

endmodule
